// File: rtl/axis_dc_ctrl_pkg.sv
// Shared types and constants for the AXIS DC filter sequencer.
package axis_dc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FAST   = 3'd1,
    ST_RAMP   = 3'd2,
    ST_TRACK  = 3'd3,
    ST_MANUAL = 3'd4
  } dc_state_t;

  // Bit 31 set tells the filter to use the dc input instead of its own estimate.
  localparam logic [31:0] MANUAL_TAU      = 32'h8000_0000;
  localparam int          WIN_LEN_DEFAULT = 4;
  localparam logic [3:0]  LOCK_RUN        = 4'd8;

endpackage

// File: rtl/axis_dc_ctrl_phase_gen.sv
// Period phase counter producing the four quarter-period sc_zero windows and
// a one-cycle window-end strobe aligned with the last sc_zero cycle.
module axis_dc_ctrl_phase_gen
  import axis_dc_ctrl_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int WIN_LEN      = WIN_LEN_DEFAULT
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  output logic                    sc_zero,
  output logic                    win_end,
  output logic                    win_end_k0
);

  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(8 * WIN_LEN);
  localparam logic [PERIOD_WIDTH-1:0] WIN_LAST   = PERIOD_WIDTH'(WIN_LEN - 1);
  localparam logic [PERIOD_WIDTH-1:0] ONE        = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] ph_q, ph_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] quarter;
  logic [PERIOD_WIDTH-1:0] base [4];
  logic                    wrap;
  logic                    sc_d, we_d, we0_d;

  // An invalid latched period keeps the counter parked at 0 and re-samples every cycle.
  assign wrap = (period_q < MIN_PERIOD) || (ph_q == period_q - ONE);

  // Outputs are computed from the next phase so the registered strobes line up with ph_q.
  always_comb begin
    period_d = period_q;
    ph_d     = ph_q + ONE;
    if (wrap) begin
      period_d = cfg_period;
      ph_d     = '0;
    end
    quarter = period_d >> 2;
    base[0] = '0;
    base[1] = quarter;
    base[2] = quarter << 1;
    base[3] = quarter + (quarter << 1);
    sc_d    = 1'b0;
    we_d    = 1'b0;
    we0_d   = 1'b0;
    if (period_d >= MIN_PERIOD) begin
      for (int k = 0; k < 4; k++) begin
        if (ph_d >= base[k] && ph_d <= base[k] + WIN_LAST) begin
          sc_d = 1'b1;
          if (ph_d == base[k] + WIN_LAST) begin
            we_d  = 1'b1;
            we0_d = (k == 0);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ph_q       <= '0;
      period_q   <= '0;
      sc_zero    <= 1'b0;
      win_end    <= 1'b0;
      win_end_k0 <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      period_q   <= period_d;
      sc_zero    <= sc_d;
      win_end    <= we_d;
      win_end_k0 <= we0_d;
    end
  end

endmodule

// File: rtl/axis_dc_filter_ctrl.sv
// AXIS DC filter sequencer: acquisition FSM (fast, ramp, track, manual) whose
// outputs only change on the cycle after a window end. Optional macro:
// DC_CTRL_LOCK_DETECT_EN adds a DC-stability qualifier on locked.
module axis_dc_filter_ctrl
  import axis_dc_ctrl_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int FAST_WIDTH   = 16,
  parameter int WIN_LEN      = WIN_LEN_DEFAULT,
  parameter int RAMP_SHIFT_W = 5
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic                    cfg_start,
  input  logic                    cfg_manual,
  input  logic [31:0]             cfg_dc_manual,
  input  logic [31:0]             cfg_tau_fast,
  input  logic [31:0]             cfg_tau_target,
  input  logic [FAST_WIDTH-1:0]   cfg_fast_len,
  input  logic [RAMP_SHIFT_W-1:0] cfg_ramp_shift,
  input  logic [31:0]             dbg_mdc,
`ifdef DC_CTRL_LOCK_DETECT_EN
  input  logic [31:0]             cfg_lock_thr,
`endif
  output logic                    sc_zero,
  output logic [31:0]             dc_tau,
  output logic [31:0]             dc,
  output logic [2:0]              state,
  output logic                    locked,
  output logic [31:0]             win_count
);

  dc_state_t             state_q, state_d;
  logic [31:0]           tau_q, tau_d, dc_q, dc_d, win_q, win_d;
  logic [FAST_WIDTH-1:0] fast_q, fast_d;
  logic                  start_d1, start_pend_q, start_pend_d, start_req;
  logic                  win_end, we_k0;
  logic signed [31:0]    step, tau_n;

  axis_dc_ctrl_phase_gen #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .WIN_LEN      (WIN_LEN)
  ) u_phase (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_period (cfg_period),
    .sc_zero    (sc_zero),
    .win_end    (win_end),
    .win_end_k0 (we_k0)
  );

  // A start edge is remembered until the next window end consumes it.
  assign start_req = start_pend_q | (cfg_start & ~start_d1);
  assign step      = signed'(tau_q) >>> cfg_ramp_shift;
  assign tau_n     = signed'(tau_q) - step;

  always_comb begin
    state_d      = state_q;
    tau_d        = tau_q;
    dc_d         = dc_q;
    win_d        = win_q;
    fast_d       = fast_q;
    start_pend_d = start_req;
    if (win_end) begin
      start_pend_d = 1'b0;
      win_d        = win_q + 32'd1;
      if (start_req) begin
        win_d  = '0;
        fast_d = '0;
        if (cfg_manual) begin
          state_d = ST_MANUAL;
          tau_d   = MANUAL_TAU;
          dc_d    = cfg_dc_manual;
        end else begin
          state_d = (cfg_fast_len == '0) ? ST_RAMP : ST_FAST;
          tau_d   = cfg_tau_fast;
        end
      end else if (cfg_manual && state_q != ST_IDLE) begin
        state_d = ST_MANUAL;
        tau_d   = MANUAL_TAU;
        dc_d    = cfg_dc_manual;
      end else begin
        case (state_q)
          ST_FAST: begin
            tau_d  = cfg_tau_fast;
            fast_d = fast_q + FAST_WIDTH'(1);
            if (fast_q + FAST_WIDTH'(1) >= cfg_fast_len) state_d = ST_RAMP;
          end
          ST_RAMP: begin
            if (tau_n <= signed'(cfg_tau_target) || step == 32'sd0) begin
              state_d = ST_TRACK;
              tau_d   = cfg_tau_target;
            end else begin
              tau_d = unsigned'(tau_n);
            end
          end
          ST_TRACK: tau_d = cfg_tau_target;
          ST_MANUAL: begin
            // cfg_manual dropped: re-acquire from scratch
            state_d = (cfg_fast_len == '0) ? ST_RAMP : ST_FAST;
            tau_d   = cfg_tau_fast;
            fast_d  = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      tau_q        <= MANUAL_TAU;
      dc_q         <= '0;
      win_q        <= '0;
      fast_q       <= '0;
      start_d1     <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tau_q        <= tau_d;
      dc_q         <= dc_d;
      win_q        <= win_d;
      fast_q       <= fast_d;
      start_d1     <= cfg_start;
      start_pend_q <= start_pend_d;
    end
  end

  assign dc_tau    = tau_q;
  assign dc        = dc_q;
  assign state     = state_q;
  assign win_count = win_q;

`ifdef DC_CTRL_LOCK_DETECT_EN
  logic [31:0]        mdc_prev_q;
  logic [3:0]         lock_cnt_q;
  logic signed [32:0] mdc_diff;
  logic [32:0]        mdc_abs;

  assign mdc_diff = signed'({dbg_mdc[31], dbg_mdc}) - signed'({mdc_prev_q[31], mdc_prev_q});
  assign mdc_abs  = mdc_diff[32] ? unsigned'(-mdc_diff) : unsigned'(mdc_diff);

  // Run length of consecutive quiet 0-degree windows while tracking, saturating at LOCK_RUN.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mdc_prev_q <= '0;
      lock_cnt_q <= '0;
    end else if (we_k0) begin
      mdc_prev_q <= dbg_mdc;
      if (state_q != ST_TRACK)                lock_cnt_q <= '0;
      else if (mdc_abs < {1'b0, cfg_lock_thr}) begin
        if (lock_cnt_q != LOCK_RUN) lock_cnt_q <= lock_cnt_q + 4'd1;
      end else                                lock_cnt_q <= '0;
    end else if (state_q != ST_TRACK) begin
      lock_cnt_q <= '0;
    end
  end

  assign locked = (state_q == ST_TRACK) && (lock_cnt_q == LOCK_RUN);
`else
  logic unused_sig;
  assign unused_sig = ^{dbg_mdc, we_k0};
  assign locked     = (state_q == ST_TRACK);
`endif

endmodule

// File: tb/tb_axis_dc_filter_ctrl.sv
// Self-checking bench for axis_dc_filter_ctrl: window pattern table, scoreboarded
// acquisition sequences, manual/restart corner cases and async reset.
module tb_axis_dc_filter_ctrl;

  localparam int PW = 24;
  localparam int FW = 16;
  localparam int WL = 4;
  localparam int RW = 5;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [PW-1:0] cfg_period;
  logic          cfg_start, cfg_manual;
  logic [31:0]   cfg_dc_manual, cfg_tau_fast, cfg_tau_target, dbg_mdc;
  logic [FW-1:0] cfg_fast_len;
  logic [RW-1:0] cfg_ramp_shift;
  logic          sc_zero, locked;
  logic [31:0]   dc_tau, dc, win_count;
  logic [2:0]    state;
`ifdef DC_CTRL_LOCK_DETECT_EN
  logic [31:0]   cfg_lock_thr = 32'd16;
`endif

  always #5 aclk = ~aclk;

  axis_dc_filter_ctrl #(
    .PERIOD_WIDTH (PW),
    .FAST_WIDTH   (FW),
    .WIN_LEN      (WL),
    .RAMP_SHIFT_W (RW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .cfg_period     (cfg_period),
    .cfg_start      (cfg_start),
    .cfg_manual     (cfg_manual),
    .cfg_dc_manual  (cfg_dc_manual),
    .cfg_tau_fast   (cfg_tau_fast),
    .cfg_tau_target (cfg_tau_target),
    .cfg_fast_len   (cfg_fast_len),
    .cfg_ramp_shift (cfg_ramp_shift),
    .dbg_mdc        (dbg_mdc),
`ifdef DC_CTRL_LOCK_DETECT_EN
    .cfg_lock_thr   (cfg_lock_thr),
`endif
    .sc_zero        (sc_zero),
    .dc_tau         (dc_tau),
    .dc             (dc),
    .state          (state),
    .locked         (locked),
    .win_count      (win_count)
  );

  typedef struct {
    int unsigned ph;
    logic        exp_sc;
  } sc_vec_t;

  sc_vec_t     sc_tab[64];
  logic [34:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the first cycle after a window end.
  task automatic wait_win_end(output bit ok);
    logic prev;
    prev = sc_zero;
    ok   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (prev && !sc_zero) begin
        ok = 1'b1;
        break;
      end
      prev = sc_zero;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL win_end_timeout: no window end within 400 cycles");
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    cfg_start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    while (exp_q.size() > 0) begin
      wait_win_end(ok);
      if (!ok) break;
      check(name, {29'd0, state, dc_tau}, {29'd0, exp_q.pop_front()});
    end
    exp_q.delete();
  endtask

  // Expected ramp trajectory from tau_fast down to target, one entry per window end.
  task automatic push_ramp(input logic [31:0] fast, input logic [31:0] tgt, input int sh);
    int signed tau, stp, tn;
    tau = signed'(fast);
    exp_q.push_back({3'd2, fast});
    for (int i = 0; i < 300; i++) begin
      stp = tau >>> sh;
      tn  = tau - stp;
      if (tn <= signed'(tgt) || stp == 0) begin
        exp_q.push_back({3'd3, tgt});
        break;
      end
      exp_q.push_back({3'd2, unsigned'(tn)});
      tau = tn;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] w0;
    int          highs;
    bit          seen;

    for (int i = 0; i < 64; i++) begin
      sc_tab[i].ph     = i;
      sc_tab[i].exp_sc = ((i % 16) < WL);
    end

    aresetn        = 1'b0;
    cfg_period     = 24'd64;
    cfg_start      = 1'b0;
    cfg_manual     = 1'b0;
    cfg_dc_manual  = '0;
    cfg_tau_fast   = 32'h4000_0000;
    cfg_tau_target = 32'h0100_0000;
    cfg_fast_len   = 16'd3;
    cfg_ramp_shift = 5'd1;
    dbg_mdc        = '0;

    repeat (3) @(negedge aclk);
    check("rst_sc_zero",   {63'd0, sc_zero}, 64'd0);
    check("rst_dc_tau",    {32'd0, dc_tau},  64'h8000_0000);
    check("rst_dc",        {32'd0, dc},      64'd0);
    check("rst_state",     {61'd0, state},   64'd0);
    check("rst_locked",    {63'd0, locked},  64'd0);
    check("rst_win_count", {32'd0, win_count}, 64'd0);

    aresetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (sc_zero) begin
        seen = 1'b1;
        break;
      end
    end
    check("sc_zero_first_rise", {63'd0, seen}, 64'd1);

    // Window pattern over one full period of 64 cycles.
    w0 = win_count;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("sc_zero_ph%0d", sc_tab[i].ph), {63'd0, sc_zero}, {63'd0, sc_tab[i].exp_sc});
      @(negedge aclk);
    end
    check("win_count_per_period", {32'd0, win_count}, {32'd0, w0 + 32'd4});

    // Acquisition: 3 windows fast, then halving ramp, then clamp to target.
    wait_win_end(ok);
    for (int i = 0; i < 3; i++) exp_q.push_back({3'd1, 32'h4000_0000});
    push_ramp(32'h4000_0000, 32'h0100_0000, 1);
    pulse_start();
    drain("acq_seq");
    check("acq_locked",    {63'd0, locked},    64'd1);
    check("acq_win_count", {32'd0, win_count}, 64'd9);

    // Restart while tracking.
    wait_win_end(ok);
    pulse_start();
    wait_win_end(ok);
    check("restart_state",  {61'd0, state},     64'd1);
    check("restart_win",    {32'd0, win_count}, 64'd0);
    check("restart_locked", {63'd0, locked},    64'd0);
    check("restart_tau",    {32'd0, dc_tau},    64'h4000_0000);
    for (int i = 0; i < 3; i++) wait_win_end(ok);
    check("ramp_entered", {61'd0, state}, 64'd2);

    // Manual override mid-ramp, then release.
    cfg_manual    = 1'b1;
    cfg_dc_manual = 32'h0004_0000;
    wait_win_end(ok);
    check("manual_state",  {61'd0, state},  64'd4);
    check("manual_tau",    {32'd0, dc_tau}, 64'h8000_0000);
    check("manual_dc",     {32'd0, dc},     64'h0004_0000);
    check("manual_locked", {63'd0, locked}, 64'd0);
    cfg_manual = 1'b0;
    wait_win_end(ok);
    check("unmanual_state", {61'd0, state},  64'd1);
    check("unmanual_tau",   {32'd0, dc_tau}, 64'h4000_0000);

    // fast_len=0 straight into ramp; run 0 uses shift 0 (immediate clamp).
    for (int r = 0; r < 4; r++) begin
      wait_win_end(ok);
      cfg_fast_len   = '0;
      cfg_tau_fast   = $urandom_range(32'h3FFF_FFFF, 32'h0100_0000);
      cfg_ramp_shift = (r == 0) ? 5'd0 : RW'($urandom_range(4, 1));
      cfg_tau_target = cfg_tau_fast >> $urandom_range(6, 2);
      push_ramp(cfg_tau_fast, cfg_tau_target, int'(cfg_ramp_shift));
      pulse_start();
      drain($sformatf("rand_ramp%0d", r));
      check($sformatf("rand_locked%0d", r), {63'd0, locked}, 64'd1);
    end

    // Asynchronous reset inside a window.
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk);
      #1;
      if (sc_zero) begin
        seen = 1'b1;
        break;
      end
    end
    check("pre_reset_in_window", {63'd0, seen}, 64'd1);
    aresetn = 1'b0;
    #1;
    check("async_sc_zero", {63'd0, sc_zero}, 64'd0);
    check("async_dc_tau",  {32'd0, dc_tau},  64'h8000_0000);
    check("async_state",   {61'd0, state},   64'd0);
    check("async_win",     {32'd0, win_count}, 64'd0);

    // Invalid period keeps the strobe off.
    cfg_period = 24'd16;
    @(negedge aclk);
    aresetn = 1'b1;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (sc_zero) highs++;
    end
    check("invalid_period_highs", 64'(highs), 64'd0);

    cfg_period = 24'd64;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (sc_zero) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_period_resume", {63'd0, seen}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
